// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD display path.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } b2b_state_t;

  localparam int BCD_DIGIT_W = 4;
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;

  // Decimal range covered by n BCD digits, used to vet parameter choices
  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) begin
      r = r * 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit's add-3 correction: applied before a shift so that a digit
// of 5 or more carries correctly into the next decimal position.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  // Add 3 (modulo 16, no carry out) when the digit has reached the threshold
  always_comb begin
    dout = din;
    if (din >= BCD_ADJ_THRESH) begin
      dout = din + 4'd3;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one input bit per clock. The result
// register only moves on completion, so the display never sees a half-built
// value, and a reset mid-conversion simply discards the work.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [WIDTH-1:0]            bin,
  output logic                        busy,
  output logic                        done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd
);

  localparam int BCD_W  = BCD_DIGIT_W * DIGITS;
  localparam int SR_W   = BCD_W + WIDTH;
  localparam int ITER_W = $clog2(WIDTH + 1);

  // Refuse to build a converter whose digits cannot hold the largest input
  if (pow10(DIGITS) <= (longint'(1) << WIDTH) - 1) begin : g_bad_params
    $error("bin_to_bcd_seq: DIGITS=%0d too small for WIDTH=%0d", DIGITS, WIDTH);
  end

  b2b_state_t        state;
  b2b_state_t        next_state;
  logic [SR_W-1:0]   shreg;
  logic [SR_W-1:0]   adj_reg;
  logic [SR_W-1:0]   shifted;
  logic [ITER_W-1:0] iter;
  logic              last_iter;

  // The binary half passes through untouched; only the digit field is corrected
  assign adj_reg[WIDTH-1:0] = shreg[WIDTH-1:0];

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_digit_adj u_adj (
      .din  (shreg[WIDTH + BCD_DIGIT_W*k +: BCD_DIGIT_W]),
      .dout (adj_reg[WIDTH + BCD_DIGIT_W*k +: BCD_DIGIT_W])
    );

    // A completed result with a digit above 9 means the adjust chain is broken
    always @(posedge clk) begin
      if (!rst && state == DONE) begin
        assert (bcd[BCD_DIGIT_W*k +: BCD_DIGIT_W] <= 4'd9)
          else $error("bin_to_bcd_seq: digit %0d out of range", k);
      end
    end
  end

  assign shifted   = {adj_reg[SR_W-2:0], 1'b0};
  assign last_iter = (iter == ITER_W'(WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state: start is only honoured in IDLE; DONE always lasts one cycle
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = SHIFT;
      SHIFT:   if (last_iter) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Status outputs decoded straight from the state
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Datapath: load on accept, adjust-and-shift per bit, publish on the last bit
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      iter  <= '0;
      bcd   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shreg <= {{BCD_W{1'b0}}, bin};
            iter  <= '0;
          end
        end
        SHIFT: begin
          shreg <= shifted;
          iter  <= iter + ITER_W'(1);
          if (last_iter) begin
            bcd <= shifted[SR_W-1 -: BCD_W];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
